// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
// master = stream source / memory side, slave = loader.
interface program_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        im_we;
    logic [15:0] im_addr;
    logic [31:0] im_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/program_loader.sv
// Fills instruction memory from a length/payload/XOR-checksum byte stream; CPU released only on a good image.
// One-cycle write strobe after each 4th payload byte (5 cycles/word peak); in_ready drops in WRITE and idle states.
module program_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    program_loader_if.slave bus,
    output logic            cpu_reset,
    output logic            busy,
    output logic            done,
    output logic            err
);
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR
    } state_t;

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  len_hi;
    logic [15:0] len;
    logic [15:0] count;
    logic [15:0] addr;
    logic [31:0] word;
    logic [1:0]  byte_idx;
    logic [7:0]  csum;
    logic        rdy;
    logic        xfer;
    logic        launch;
    logic [15:0] len_now;

    assign rdy     = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                     (state == S_DATA)   || (state == S_CHECK);
    assign xfer    = bus.in_valid & rdy;
    assign launch  = start & ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
    assign len_now = {len_hi, bus.in_data};

    assign bus.in_ready = rdy;
    assign bus.im_we    = (state == S_WRITE);
    assign bus.im_addr  = addr;
    assign bus.im_wdata = word;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cpu_reset = 1'b1;
        busy      = 1'b1;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (xfer) state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (xfer) begin
                    if (len_now == 16'd0)               state_nxt = S_CHECK;
                    else if ({1'b0, len_now} > MAX_W)   state_nxt = S_ERROR;
                    else                                state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer && (byte_idx == 2'd3)) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                // count still holds the words written before this one
                if ((count + 16'd1) == len) state_nxt = S_CHECK;
                else                        state_nxt = S_DATA;
            end
            S_CHECK: begin
                if (xfer) state_nxt = (bus.in_data == csum) ? S_DONE : S_ERROR;
            end
            S_DONE: begin
                busy      = 1'b0;
                done      = 1'b1;
                cpu_reset = 1'b0;
                if (start) state_nxt = S_LEN_HI;
            end
            S_ERROR: begin
                busy = 1'b0;
                err  = 1'b1;
                if (start) state_nxt = S_LEN_HI;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            len_hi   <= 8'd0;
            len      <= 16'd0;
            count    <= 16'd0;
            addr     <= BASE_ADDR;
            word     <= 32'd0;
            byte_idx <= 2'd0;
            csum     <= 8'd0;
        end else if (launch) begin
            count    <= 16'd0;
            addr     <= BASE_ADDR;
            byte_idx <= 2'd0;
            csum     <= 8'd0;
        end else begin
            case (state)
                S_LEN_HI: if (xfer) len_hi <= bus.in_data;
                S_LEN_LO: if (xfer) len <= len_now;
                S_DATA: begin
                    if (xfer) begin
                        word     <= {word[23:0], bus.in_data};
                        csum     <= csum ^ bus.in_data;
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                S_WRITE: begin
                    addr  <= addr + 16'd4;
                    count <= count + 16'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: table of whole images plus reset-abort and idle-input sequences.
module tb_program_loader;
    localparam logic [15:0] BASE = 16'h0000;

    typedef struct packed {
        logic [127:0] bytes;      // stream, left-justified, first byte in [127:120]
        int           nbytes;
        bit           gaps;
        bit           exp_done;
        bit           exp_err;
        int           exp_writes;
        int           exp_cycles;
    } vec_t;

    logic clk;
    logic reset;
    logic start;
    logic cpu_reset, busy, done, err;

    program_loader_if bus ();

    program_loader #(.BASE_ADDR(BASE), .MAX_WORDS(1024)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus.slave),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          writes = 0;
    logic [47:0] sb[$];
    logic [15:0] exp_addr;
    vec_t        vecs[6];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest word the stream model completed.
    always @(negedge clk) begin
        if (bus.im_we === 1'b1) begin
            logic [47:0] e;
            writes++;
            chk("in_ready_in_write", 48'(bus.in_ready), 48'd0);
            if (sb.size() == 0) begin
                chk("unexpected_write", 48'(bus.im_addr), 48'hFFFF_FFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("im_addr", 48'(bus.im_addr), 48'(e[47:32]));
                chk("im_wdata", 48'(bus.im_wdata), 48'(e[31:0]));
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_addr = BASE;
        chk("start_busy", 48'(busy), 48'd1);
        chk("start_done", 48'(done), 48'd0);
        chk("start_err", 48'(err), 48'd0);
        chk("start_cpu_reset", 48'(cpu_reset), 48'd1);
        chk("start_im_addr", 48'(bus.im_addr), 48'(BASE));
    endtask

    // Sends nbytes of the stream; pushes expected words as the 4th payload byte of each is accepted.
    task automatic send(input vec_t v, input int nbytes, output int cyc);
        logic [15:0] n;
        logic [31:0] w;
        logic [7:0]  b;
        int          g;
        bit          acc;
        bit          r;
        n   = v.bytes[127:112];
        w   = 32'd0;
        cyc = 0;
        for (int i = 0; i < nbytes; i++) begin
            g = v.gaps ? ((i == 3) ? 2 : (i % 2)) : 0;
            b = v.bytes[127 - 8*i -: 8];
            repeat (g) begin
                bus.in_valid = 1'b0;
                @(posedge clk); cyc++; #1;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = b;
            acc = 1'b0;
            for (int t = 0; t < 40 && !acc; t++) begin
                r = bus.in_ready;
                @(posedge clk); cyc++;
                if (r) begin
                    acc = 1'b1;
                    if (i >= 2 && i < 2 + 4*int'(n) && n <= 16'd1024) begin
                        w = {w[23:0], b};
                        if (((i - 2) % 4) == 3) begin
                            sb.push_back({exp_addr, w});
                            exp_addr = exp_addr + 16'd4;
                        end
                    end
                end
                #1;
            end
            if (!acc) begin
                chk("byte_accept_timeout", 48'(i), 48'hFFFF);
                bus.in_valid = 1'b0;
                return;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc;
        int w0;
        w0 = writes;
        pulse_start();
        send(v, v.nbytes, cyc);
        chk($sformatf("v%0d_cycles", idx), 48'(cyc), 48'(v.exp_cycles));
        chk($sformatf("v%0d_done", idx), 48'(done), 48'(v.exp_done));
        chk($sformatf("v%0d_err", idx), 48'(err), 48'(v.exp_err));
        chk($sformatf("v%0d_cpu_reset", idx), 48'(cpu_reset), 48'(!v.exp_done));
        chk($sformatf("v%0d_busy", idx), 48'(busy), 48'd0);
        chk($sformatf("v%0d_in_ready", idx), 48'(bus.in_ready), 48'd0);
        chk($sformatf("v%0d_writes", idx), 48'(writes - w0), 48'(v.exp_writes));
        chk($sformatf("v%0d_end_addr", idx), 48'(bus.im_addr), 48'(exp_addr));
        chk($sformatf("v%0d_sb_empty", idx), 48'(sb.size()), 48'd0);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_in_ready"}, 48'(bus.in_ready), 48'd0);
        chk({tag, "_im_we"}, 48'(bus.im_we), 48'd0);
        chk({tag, "_im_addr"}, 48'(bus.im_addr), 48'(BASE));
        chk({tag, "_im_wdata"}, 48'(bus.im_wdata), 48'd0);
        chk({tag, "_cpu_reset"}, 48'(cpu_reset), 48'd1);
        chk({tag, "_busy"}, 48'(busy), 48'd0);
        chk({tag, "_done"}, 48'(done), 48'd0);
        chk({tag, "_err"}, 48'(err), 48'd0);
    endtask

    initial begin
        int   cyc;
        int   w0;
        vec_t part;

        // Payload XOR of 20 08 00 05 8C 09 00 04 is 0xAC.
        vecs[0] = '{bytes: {88'h0002_2008_0005_8C09_0004_AC, 40'h0}, nbytes: 11, gaps: 1'b0,
                    exp_done: 1'b1, exp_err: 1'b0, exp_writes: 2, exp_cycles: 13};
        vecs[1] = '{bytes: {88'h0002_2008_0005_8C09_0004_AD, 40'h0}, nbytes: 11, gaps: 1'b0,
                    exp_done: 1'b0, exp_err: 1'b1, exp_writes: 2, exp_cycles: 13};
        vecs[2] = '{bytes: {16'h0401, 112'h0}, nbytes: 2, gaps: 1'b0,
                    exp_done: 1'b0, exp_err: 1'b1, exp_writes: 0, exp_cycles: 2};
        // 7 accepted + 4 idle cycles + 1 WRITE cycle blocking the checksum byte.
        vecs[3] = '{bytes: {56'h0001_DEAD_BEEF_22, 72'h0}, nbytes: 7, gaps: 1'b1,
                    exp_done: 1'b1, exp_err: 1'b0, exp_writes: 1, exp_cycles: 12};
        vecs[4] = '{bytes: {24'h0000_00, 104'h0}, nbytes: 3, gaps: 1'b0,
                    exp_done: 1'b1, exp_err: 1'b0, exp_writes: 0, exp_cycles: 3};
        vecs[5] = '{bytes: {56'h0001_1234_5678_08, 72'h0}, nbytes: 7, gaps: 1'b0,
                    exp_done: 1'b1, exp_err: 1'b0, exp_writes: 1, exp_cycles: 8};

        reset        = 1'b0;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        exp_addr     = BASE;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_values("rst");
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i);
            @(posedge clk); #1;
        end

        // Reset in the middle of a word: nothing from the aborted load may be written.
        part = vecs[5];
        part.bytes = {32'h0001_AABB, 96'h0};
        pulse_start();
        send(part, 4, cyc);
        reset = 1'b0;
        @(posedge clk); #1;
        chk_reset_values("abort");
        @(posedge clk); #1;
        reset = 1'b1;
        chk("abort_sb_empty", 48'(sb.size()), 48'd0);
        @(posedge clk); #1;
        run_vec(vecs[5], 6);

        // Bytes offered while DONE are ignored.
        w0 = writes;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_in_ready", 48'(bus.in_ready), 48'd0);
        chk("idle_done", 48'(done), 48'd1);
        chk("idle_busy", 48'(busy), 48'd0);
        chk("idle_writes", 48'(writes - w0), 48'd0);
        bus.in_valid = 1'b0;

        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1);
    end
endmodule
